// File: rtl/icache_assoc.sv
// ---------------------------------------------------------------------------
// icache_assoc -- two-way set-associative, read-only instruction cache.
//
// Each line holds WORDS_PER_LINE 32-bit words. A miss refills the whole line
// from memory one word per beat, in order from word 0, and then answers the
// fetch. Each set has one LRU bit. A flush invalidates every line; if it
// arrives while a request is in flight, it is held until the request
// completes.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   cpu_req_addr     fetch byte address (bits [1:0] ignored)
//   cpu_req_valid    fetch request, accepted only in IDLE
//   cpu_req_data     fetched word; holds its last value between responses
//   cpu_req_ready    one-cycle pulse: cpu_req_data valid, request complete
//   flush            invalidate-all request
//   busy             high outside IDLE or while a flush is pending
//   mem_req_addr     word-aligned refill beat address (0 when not refilling)
//   mem_req_valid    refill beat request
//   mem_req_ready    beat complete, mem_req_data valid in the same cycle
//   mem_req_data     refill beat data
//   hit_count        lookups that hit (wraps modulo 2**32)
//   miss_count       lookups that missed (wraps modulo 2**32)
// ---------------------------------------------------------------------------
module icache_assoc #(
    parameter int ADDR_WIDTH     = 32,
    parameter int INDEX_BITS     = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic                  cpu_req_valid,
    output logic [31:0]           cpu_req_data,
    output logic                  cpu_req_ready,
    input  logic                  flush,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    input  logic [31:0]           mem_req_data,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int SETS      = 2 ** INDEX_BITS;
    localparam int OFF_BITS  = $clog2(WORDS_PER_LINE);
    localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - OFF_BITS - 2;
    localparam int LINE_BITS = INDEX_BITS + OFF_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_RESP,
        S_FLUSH
    } state_t;

    state_t state_q, state_d;

    // Latched request: only the word address is kept.
    logic [ADDR_WIDTH-1:2] req_addr_q;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [OFF_BITS-1:0]   req_off;

    logic                  flush_pend_q;
    logic [OFF_BITS-1:0]   beat_q;
    logic                  victim_q;
    logic [31:0]           data_hold_q;

    // Line state: valid bits and LRU bits are reset; tags and data are not.
    logic [SETS-1:0]       valid_q [2];
    logic [SETS-1:0]       lru_q;
    logic [TAG_BITS-1:0]   tag_mem  [2][SETS];
    logic [31:0]           data_mem [2][SETS*WORDS_PER_LINE];

    logic                  hit0, hit1, hit, hit_way;
    logic                  victim_sel;
    logic                  flush_req;
    logic                  accept;
    logic                  beat_done;
    logic                  last_beat;
    logic [31:0]           hit_word;
    logic [31:0]           resp_word;

    // The byte-lane bits of the fetch address have no meaning here.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^cpu_req_addr[1:0];

    assign req_tag = req_addr_q[ADDR_WIDTH-1:LINE_BITS+2];
    assign req_idx = req_addr_q[LINE_BITS+1:OFF_BITS+2];
    assign req_off = req_addr_q[OFF_BITS+1:2];

    assign hit0    = valid_q[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
    assign hit1    = valid_q[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;

    // Fill an empty way first (way 0 before way 1); otherwise evict the LRU way.
    assign victim_sel = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

    assign hit_word  = data_mem[hit_way][{req_idx, req_off}];
    assign resp_word = data_mem[victim_q][{req_idx, req_off}];

    assign flush_req = flush || flush_pend_q;
    assign accept    = (state_q == S_IDLE) && !flush_req && cpu_req_valid;
    assign beat_done = (state_q == S_REFILL) && mem_req_ready;
    assign last_beat = (beat_q == OFF_BITS'(WORDS_PER_LINE - 1));

    assign busy = (state_q != S_IDLE) || flush_pend_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d       = state_q;
        cpu_req_ready = 1'b0;
        cpu_req_data  = data_hold_q;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;

        case (state_q)
            S_IDLE: begin
                if (flush_req)          state_d = S_FLUSH;
                else if (cpu_req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    cpu_req_ready = 1'b1;
                    cpu_req_data  = hit_word;
                    state_d       = S_IDLE;
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_addr_q[ADDR_WIDTH-1:OFF_BITS+2], beat_q, 2'b00};
                if (mem_req_ready && last_beat) state_d = S_RESP;
            end
            S_RESP: begin
                cpu_req_ready = 1'b1;
                cpu_req_data  = resp_word;
                state_d       = S_IDLE;
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers, line state and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <=, so every register
        // here samples the values from before this edge regardless of order.
        if (rst) begin
            req_addr_q   <= '0;
            flush_pend_q <= 1'b0;
            beat_q       <= '0;
            victim_q     <= 1'b0;
            data_hold_q  <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
            valid_q[0]   <= '0;
            valid_q[1]   <= '0;
            lru_q        <= '0;
        end else begin
            if (accept) req_addr_q <= cpu_req_addr[ADDR_WIDTH-1:2];

            // A flush outside IDLE waits for the in-flight request; one that
            // arrives during FLUSH itself is already covered.
            if (state_q == S_FLUSH)
                flush_pend_q <= 1'b0;
            else if (flush && (state_q != S_IDLE))
                flush_pend_q <= 1'b1;

            case (state_q)
                S_LOOKUP: begin
                    if (hit) begin
                        lru_q[req_idx] <= ~hit_way;
                        data_hold_q    <= hit_word;
                        hit_count      <= hit_count + 32'd1;
                    end else begin
                        victim_q                <= victim_sel;
                        valid_q[victim_sel][req_idx] <= 1'b0;
                        beat_q                  <= '0;
                        miss_count              <= miss_count + 32'd1;
                    end
                end
                S_REFILL: begin
                    if (mem_req_ready) begin
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) valid_q[victim_q][req_idx] <= 1'b1;
                    end
                end
                S_RESP: begin
                    lru_q[req_idx] <= ~victim_q;
                    data_hold_q    <= resp_word;
                end
                S_FLUSH: begin
                    valid_q[0] <= '0;
                    valid_q[1] <= '0;
                    lru_q      <= '0;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tag and data storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the arrays are left out of reset on purpose; a line's contents
        // are never used unless its valid bit is set, and the valid bits are reset.
        if (beat_done) begin
            data_mem[victim_q][{req_idx, beat_q}] <= mem_req_data;
            if (last_beat) tag_mem[victim_q][req_idx] <= req_tag;
        end
    end

endmodule
